mpsoc_dma_entry_scheduler: RTL and testbench

Round-robin scheduler that shares the single network-adapter DMA transfer engine among the NA DMA request-table entries of one compute tile. It watches software-set entry valid bits, issues one entry at a time to the engine with a start/ready handshake, waits for completion under a watchdog, then retires the entry and raises a per-entry interrupt. It sits between the DMA request table and the DMA transfer engine inside the network adapter and is instantiated only when DMA is enabled in the tile configuration.

---
 rtl/mpsoc_dma_entry_scheduler_if.sv | 36 +++
 rtl/mpsoc_dma_entry_scheduler.sv | 142 ++++++++++++++
 tb/tb_mpsoc_dma_entry_scheduler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_dma_entry_scheduler_if.sv
// mpsoc_dma_entry_scheduler_if
//   Handshake bundle between the DMA entry scheduler and the NA DMA transfer
//   engine.
//   ctrl_start  scheduler -> engine  request, held until ctrl_ready
//   ctrl_idx    scheduler -> engine  request-table index of the transfer
//   ctrl_abort  scheduler -> engine  one-cycle watchdog abort pulse
//   ctrl_ready  engine -> scheduler  engine accepted ctrl_idx
//   ctrl_done   engine -> scheduler  accepted transfer finished (pulse)
//   master: scheduler side, slave: engine side.
interface mpsoc_dma_entry_scheduler_if #(
    parameter int unsigned TABLE_ENTRIES = 4
);
    localparam int unsigned IW = (TABLE_ENTRIES > 1) ? $clog2(TABLE_ENTRIES) : 1;

    logic          ctrl_start;
    logic [IW-1:0] ctrl_idx;
    logic          ctrl_abort;
    logic          ctrl_ready;
    logic          ctrl_done;

    modport master (
        output ctrl_start,
        output ctrl_idx,
        output ctrl_abort,
        input  ctrl_ready,
        input  ctrl_done
    );

    modport slave (
        input  ctrl_start,
        input  ctrl_idx,
        input  ctrl_abort,
        output ctrl_ready,
        output ctrl_done
    );
endinterface

// File: rtl/mpsoc_dma_entry_scheduler.sv
// mpsoc_dma_entry_scheduler
//   Round-robin scheduler sharing the single NA DMA transfer engine among the
//   DMA request-table entries of one tile. Issues one valid entry at a time,
//   waits for completion under a watchdog, then retires the entry and raises
//   a per-entry interrupt (or error flag on timeout).
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        permit new issues (an accepted transfer always completes)
//   entry_valid   pending request per table entry
//   entry_clear   one-cycle pulse clearing the valid bit of a retired entry
//   ctrl          engine handshake (start/idx/abort out, ready/done in)
//   irq_pending   sticky completion flags, cleared by irq_ack
//   irq_ack       clears matching irq_pending / err_pending bits
//   err_pending   sticky timeout flags, cleared by irq_ack
//   busy          high while a transfer is being issued, waited on or retired
module mpsoc_dma_entry_scheduler #(
    parameter int unsigned TABLE_ENTRIES      = 4,
    parameter bit          GENERATE_INTERRUPT = 1'b1,
    parameter int unsigned TIMEOUT            = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [TABLE_ENTRIES-1:0]      entry_valid,
    output logic [TABLE_ENTRIES-1:0]      entry_clear,
    mpsoc_dma_entry_scheduler_if.master   ctrl,
    output logic [TABLE_ENTRIES-1:0]      irq_pending,
    input  logic [TABLE_ENTRIES-1:0]      irq_ack,
    output logic [TABLE_ENTRIES-1:0]      err_pending,
    output logic                          busy
);
    localparam int unsigned IW = (TABLE_ENTRIES > 1) ? $clog2(TABLE_ENTRIES) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETIRE
    } state_t;

    state_t                   state;
    logic [IW-1:0]            last_ptr;
    logic [CW-1:0]            wait_cnt;

    logic [IW-1:0]            sel_idx;
    logic                     sel_found;
    logic [IW:0]              probe;
    logic [TABLE_ENTRIES-1:0] cur_onehot;
    logic                     done_hit;
    logic                     timeout_hit;
    logic [TABLE_ENTRIES-1:0] irq_set;
    logic [TABLE_ENTRIES-1:0] err_set;

    // Round-robin search: first valid entry above last_ptr, wrapping.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        probe     = '0;
        for (int unsigned k = 1; k <= TABLE_ENTRIES; k++) begin
            probe = {1'b0, last_ptr} + (IW+1)'(k);
            if (probe >= (IW+1)'(TABLE_ENTRIES)) begin
                probe = probe - (IW+1)'(TABLE_ENTRIES);
            end
            if (!sel_found && entry_valid[probe[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = probe[IW-1:0];
            end
        end
    end

    // A done on the final watchdog cycle counts as a normal completion.
    always_comb begin
        cur_onehot  = TABLE_ENTRIES'(1) << ctrl.ctrl_idx;
        done_hit    = (state == ST_WAIT) && ctrl.ctrl_done;
        timeout_hit = (state == ST_WAIT) && !ctrl.ctrl_done &&
                      (wait_cnt == CW'(TIMEOUT - 1));
        irq_set     = (done_hit && GENERATE_INTERRUPT) ? cur_onehot : '0;
        err_set     = timeout_hit ? cur_onehot : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            last_ptr        <= IW'(TABLE_ENTRIES - 1);
            wait_cnt        <= '0;
            ctrl.ctrl_start <= 1'b0;
            ctrl.ctrl_idx   <= '0;
            ctrl.ctrl_abort <= 1'b0;
            entry_clear     <= '0;
            irq_pending     <= '0;
            err_pending     <= '0;
            busy            <= 1'b0;
        end else begin
            entry_clear     <= '0;
            ctrl.ctrl_abort <= 1'b0;
            // Set wins over a same-cycle acknowledge.
            irq_pending     <= (irq_pending & ~irq_ack) | irq_set;
            err_pending     <= (err_pending & ~irq_ack) | err_set;

            case (state)
                ST_IDLE: begin
                    if (enable && sel_found) begin
                        ctrl.ctrl_idx   <= sel_idx;
                        ctrl.ctrl_start <= 1'b1;
                        busy            <= 1'b1;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ctrl.ctrl_ready) begin
                        ctrl.ctrl_start <= 1'b0;
                        // Preloaded to 1 so the abort pulse lands exactly
                        // TIMEOUT cycles after the ready cycle.
                        wait_cnt        <= CW'(1);
                        state           <= ST_WAIT;
                    end else if (!entry_valid[ctrl.ctrl_idx]) begin
                        ctrl.ctrl_start <= 1'b0;
                        busy            <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (done_hit || timeout_hit) begin
                        entry_clear     <= cur_onehot;
                        ctrl.ctrl_abort <= timeout_hit;
                        last_ptr        <= ctrl.ctrl_idx;
                        state           <= ST_RETIRE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_RETIRE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mpsoc_dma_entry_scheduler.sv
// tb_mpsoc_dma_entry_scheduler
//   Directed scenarios plus randomized traffic against a transaction-level
//   reference model (round-robin pick by arithmetic, cycle stamps for the
//   watchdog, set/ack bitmasks for the sticky flags).
module tb_mpsoc_dma_entry_scheduler;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    localparam int P_NONE = 0;
    localparam int P_REQ  = 1;
    localparam int P_ACC  = 2;
    localparam int P_RET  = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable;
    logic [N-1:0] entry_valid;
    logic [N-1:0] entry_clear;
    logic [N-1:0] irq_pending;
    logic [N-1:0] irq_ack;
    logic [N-1:0] err_pending;
    logic         busy;

    mpsoc_dma_entry_scheduler_if #(.TABLE_ENTRIES(N)) ctrl_if ();

    mpsoc_dma_entry_scheduler #(
        .TABLE_ENTRIES      (N),
        .GENERATE_INTERRUPT (1'b1),
        .TIMEOUT            (TO)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .entry_valid (entry_valid),
        .entry_clear (entry_clear),
        .ctrl        (ctrl_if),
        .irq_pending (irq_pending),
        .irq_ack     (irq_ack),
        .err_pending (err_pending),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus for the next edge
    logic         d_en;
    logic [N-1:0] d_valid;
    logic         d_ready;
    logic         d_done;
    logic [N-1:0] d_ack;

    // Reference model
    int           ph;
    int           cur;
    int           last_ret;
    int           cyc;
    int           acc_cyc;
    logic [N-1:0] exp_irq;
    logic [N-1:0] exp_err;
    int           issue_log[$];

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            int j;
            j = (last + k) % int'(N);
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic step();
        logic         a_en, a_ready, a_done, e_abort, new_issue;
        logic [N-1:0] a_valid, a_ack, set_i, set_e, e_clear;
        a_en = d_en; a_valid = d_valid; a_ready = d_ready; a_done = d_done; a_ack = d_ack;
        enable               = a_en;
        entry_valid          = a_valid;
        ctrl_if.ctrl_ready   = a_ready;
        ctrl_if.ctrl_done    = a_done;
        irq_ack              = a_ack;
        @(posedge clk);
        #1;
        cyc++;
        set_i = '0; set_e = '0; e_clear = '0; e_abort = 1'b0; new_issue = 1'b0;
        case (ph)
            P_NONE: begin
                if (a_en && (|a_valid)) begin
                    cur = rr_pick(a_valid, last_ret);
                    ph = P_REQ;
                    new_issue = 1'b1;
                end
            end
            P_REQ: begin
                if (a_ready) begin
                    ph = P_ACC;
                    acc_cyc = cyc - 1;
                end else if (!a_valid[cur]) begin
                    ph = P_NONE;
                end
            end
            P_ACC: begin
                if (a_done) begin
                    ph = P_RET;
                    e_clear = N'(1 << cur);
                    set_i = N'(1 << cur);
                    last_ret = cur;
                end else if (cyc == acc_cyc + int'(TO)) begin
                    ph = P_RET;
                    e_clear = N'(1 << cur);
                    set_e = N'(1 << cur);
                    e_abort = 1'b1;
                    last_ret = cur;
                end
            end
            default: ph = P_NONE;
        endcase
        exp_irq = (exp_irq & ~a_ack) | set_i;
        exp_err = (exp_err & ~a_ack) | set_e;

        check_eq("start", 32'(ctrl_if.ctrl_start), 32'(ph == P_REQ));
        if (ph != P_NONE) check_eq("idx", 32'(ctrl_if.ctrl_idx), 32'(cur));
        check_eq("busy", 32'(busy), 32'(ph != P_NONE));
        check_eq("entry_clear", 32'(entry_clear), 32'(e_clear));
        check_eq("abort", 32'(ctrl_if.ctrl_abort), 32'(e_abort));
        check_eq("irq_pending", 32'(irq_pending), 32'(exp_irq));
        check_eq("err_pending", 32'(err_pending), 32'(exp_err));
        if (new_issue) issue_log.push_back(int'(ctrl_if.ctrl_idx));
        d_valid = d_valid & ~e_clear;
    endtask

    task automatic reset_all();
        d_en = 1'b0; d_valid = '0; d_ready = 1'b0; d_done = 1'b0; d_ack = '0;
        rst_n = 1'b0;
        enable = 1'b0; entry_valid = '0; irq_ack = '0;
        ctrl_if.ctrl_ready = 1'b0; ctrl_if.ctrl_done = 1'b0;
        #2;
        check_eq("rst_start", 32'(ctrl_if.ctrl_start), 0);
        check_eq("rst_idx", 32'(ctrl_if.ctrl_idx), 0);
        check_eq("rst_clear", 32'(entry_clear), 0);
        check_eq("rst_abort", 32'(ctrl_if.ctrl_abort), 0);
        check_eq("rst_irq", 32'(irq_pending), 0);
        check_eq("rst_err", 32'(err_pending), 0);
        check_eq("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph = P_NONE; last_ret = int'(N) - 1; exp_irq = '0; exp_err = '0;
        issue_log.delete();
    endtask

    task automatic issue_wait(input int budget);
        for (int i = 0; i < budget && ph != P_REQ; i++) step();
        check_eq("issue_seen", 32'(ctrl_if.ctrl_start), 1);
    endtask

    task automatic run_xfer(input int ready_lat, input int done_lat);
        repeat (ready_lat) step();
        d_ready = 1'b1; step(); d_ready = 1'b0;
        repeat (done_lat) step();
        d_done = 1'b1; step(); d_done = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_cyc;
        int abort_cyc;
        int exp_order[5];
        logic [N-1:0] irq_before;
        cyc = 0;
        reset_all();

        // Single entry
        d_en = 1'b1; d_valid = 4'b0001;
        issue_wait(4);
        check_eq("single_idx", 32'(ctrl_if.ctrl_idx), 0);
        run_xfer(2, 4);
        check_eq("single_irq", 32'(irq_pending), 32'h1);
        check_eq("single_busy", 32'(busy), 0);
        d_ack = 4'b0001; step(); d_ack = '0;
        check_eq("single_ack", 32'(irq_pending), 0);

        // Fairness with all entries constantly re-requested
        reset_all();
        d_en = 1'b1; d_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            issue_wait(4);
            run_xfer(0, 1);
            d_valid = 4'b1111;
        end
        exp_order = '{0, 1, 2, 3, 0};
        check_eq("fair_count", 32'(issue_log.size()), 5);
        for (int t = 0; t < 5 && t < issue_log.size(); t++)
            check_eq("fair_order", 32'(issue_log[t]), 32'(exp_order[t]));

        // Software cancel before ready
        reset_all();
        d_en = 1'b1; d_valid = 4'b0100;
        issue_wait(4);
        check_eq("cancel_idx", 32'(ctrl_if.ctrl_idx), 2);
        step();
        d_valid = '0; step();
        check_eq("cancel_busy", 32'(busy), 0);
        check_eq("cancel_irq", 32'(irq_pending), 0);
        d_valid = 4'b0010;
        issue_wait(4);
        check_eq("cancel_next_idx", 32'(ctrl_if.ctrl_idx), 1);
        run_xfer(1, 2);

        // Watchdog
        d_valid = 4'b0001;
        issue_wait(4);
        ready_cyc = cyc;
        abort_cyc = -1;
        irq_before = exp_irq;
        d_ready = 1'b1; step(); d_ready = 1'b0;
        for (int i = 0; i < 12 && ph != P_RET; i++) begin
            step();
            if (ctrl_if.ctrl_abort === 1'b1 && abort_cyc < 0) abort_cyc = cyc;
        end
        check_eq("timeout_delay", 32'(abort_cyc - ready_cyc), TO);
        check_eq("timeout_err", 32'(err_pending), 32'h1);
        check_eq("timeout_irq", 32'(irq_pending), 32'(irq_before));
        check_eq("timeout_clear", 32'(entry_clear), 32'h1);
        step();

        // Ack colliding with retire of entry 0
        d_valid = 4'b0001;
        issue_wait(4);
        d_ready = 1'b1; step(); d_ready = 1'b0;
        step(); step();
        d_done = 1'b1; d_ack = 4'b0001; step(); d_done = 1'b0;
        check_eq("collide_irq_set", 32'(irq_pending[0]), 1);
        step(); d_ack = '0;
        check_eq("collide_irq_ack", 32'(irq_pending[0]), 0);

        // Enable dropped during WAIT
        reset_all();
        d_en = 1'b1; d_valid = 4'b0011;
        issue_wait(4);
        check_eq("en_first_idx", 32'(ctrl_if.ctrl_idx), 0);
        d_ready = 1'b1; step(); d_ready = 1'b0;
        d_en = 1'b0;
        step(); step();
        d_done = 1'b1; step(); d_done = 1'b0;
        repeat (6) step();
        check_eq("en_hold_start", 32'(ctrl_if.ctrl_start), 0);
        check_eq("en_hold_busy", 32'(busy), 0);
        d_en = 1'b1;
        issue_wait(4);
        check_eq("en_resume_idx", 32'(ctrl_if.ctrl_idx), 1);
        run_xfer(0, 1);

        // Asynchronous reset in the middle of a transfer
        d_valid = 4'b1000;
        issue_wait(4);
        d_ready = 1'b1; step(); d_ready = 1'b0;
        step();
        reset_all();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            d_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) d_valid = d_valid | N'($urandom_range(0, 15));
            d_ready = (ph == P_REQ) && ($urandom_range(0, 1) == 1);
            if (ph == P_REQ && !d_ready && $urandom_range(0, 15) == 0) d_valid[cur] = 1'b0;
            if (ph == P_ACC) d_done = ($urandom_range(0, 5) == 0);
            else             d_done = ($urandom_range(0, 7) == 0);
            d_ack = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
